// File: rtl/led_display_package.sv
// Shared definitions for the HUB75 frame reader: channel codes and the flat RGB row layout.
package led_display_package;

    localparam int GL_RGB_CHANNELS = 6;
    localparam int GL_ROW_W        = 32;

    typedef enum logic [2:0] {
        CH_TOP_R = 3'd0,
        CH_TOP_G = 3'd1,
        CH_TOP_B = 3'd2,
        CH_BOT_R = 3'd3,
        CH_BOT_G = 3'd4,
        CH_BOT_B = 3'd5
    } channel_e;

    // Member order puts top_r in the LSBs of the flat row word.
    typedef struct packed {
        logic [GL_ROW_W-1:0] bot_b;
        logic [GL_ROW_W-1:0] bot_g;
        logic [GL_ROW_W-1:0] bot_r;
        logic [GL_ROW_W-1:0] top_b;
        logic [GL_ROW_W-1:0] top_g;
        logic [GL_ROW_W-1:0] top_r;
    } rgb_row_t;

    function automatic logic [GL_RGB_CHANNELS*GL_ROW_W-1:0] pack_row(input rgb_row_t r);
        return {r.bot_b, r.bot_g, r.bot_r, r.top_b, r.top_g, r.top_r};
    endfunction

    function automatic rgb_row_t unpack_row(input logic [GL_RGB_CHANNELS*GL_ROW_W-1:0] flat);
        rgb_row_t r;
        {r.bot_b, r.bot_g, r.bot_r, r.top_b, r.top_g, r.top_r} = flat;
        return r;
    endfunction

endpackage

// File: rtl/led_display_rdata_tagger.sv
// Tag pipe that follows each RAM read so returning data can be steered to its channel slot.
module led_display_rdata_tagger #(
    parameter int LATENCY = 1
) (
    input  logic       clk_in,
    input  logic       n_reset_in,
    input  logic       issue_in,
    input  logic [2:0] chan_in,
    output logic       tag_valid_out,
    output logic [2:0] tag_chan_out
);

    typedef struct packed {
        logic       valid;
        logic [2:0] chan;
    } tag_t;

    tag_t pipe [LATENCY];

    // NOTE: non-blocking assignments let every stage sample its neighbour's pre-edge value.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= '{valid: issue_in, chan: chan_in};
            for (int i = 1; i < LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign tag_valid_out = pipe[LATENCY-1].valid;
    assign tag_chan_out  = pipe[LATENCY-1].chan;

endmodule

// File: rtl/led_display_frame_reader.sv
// Frame-buffer reader: fetches six channel words per scan row, assembles them and
// presents the row on a valid/ready port while the next row is prefetched.
module led_display_frame_reader
    import led_display_package::*;
#(
    parameter int ROW_W       = 32,
    parameter int SCAN_ROWS   = 16,
    parameter int RAM_LATENCY = 1,
    parameter int ROW_ADDR_W  = $clog2(SCAN_ROWS),
    parameter int RAM_ADDR_W  = ROW_ADDR_W + 4
) (
    input  logic                         clk_in,
    input  logic                         n_reset_in,
    input  logic                         enable_in,
    input  logic                         bank_swap_in,
    output logic                         swap_ack_out,
    output logic                         bank_out,
    output logic                         ram_rd_en_out,
    output logic [RAM_ADDR_W-1:0]        ram_address_out,
    input  logic [ROW_W-1:0]             ram_rdata_in,
    output logic [GL_RGB_CHANNELS*ROW_W-1:0] row_data_out,
    output logic                         row_valid_out,
    output logic [ROW_ADDR_W-1:0]        row_address_out,
    output logic                         row_first_out,
    input  logic                         row_ready_in
);

    if (RAM_LATENCY < 1 || RAM_LATENCY > 4) begin : g_bad_latency
        $error("led_display_frame_reader: RAM_LATENCY must be in 1..4");
    end
    if (SCAN_ROWS < 2 || (SCAN_ROWS & (SCAN_ROWS - 1)) != 0) begin : g_bad_rows
        $error("led_display_frame_reader: SCAN_ROWS must be a power of 2, >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_FULL  = 2'd3
    } state_e;

    state_e                          state, state_next;
    channel_e                        chan;
    logic [ROW_ADDR_W-1:0]           row, asm_row;
    logic                            bank, swap_pending;
    logic                            issue, swap_now, eff_bank, load;
    logic                            tag_valid;
    logic [2:0]                      tag_chan;
    logic [ROW_W-1:0]                slot [GL_RGB_CHANNELS];
    logic [GL_RGB_CHANNELS*ROW_W-1:0] asm_flat;

    assign issue    = (state == S_ISSUE);
    // The swap lands on the very first read of a new frame, so that read already uses the new bank.
    assign swap_now = issue && (chan == CH_TOP_R) && (row == '0) && swap_pending;
    assign eff_bank = bank ^ swap_now;
    assign load     = (state == S_FULL) && (!row_valid_out || row_ready_in);

    assign ram_rd_en_out   = issue;
    assign ram_address_out = issue ? {eff_bank, row, chan} : '0;
    assign swap_ack_out    = swap_now;
    assign bank_out        = eff_bank;

    // NOTE: state_next takes a default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (enable_in) state_next = S_ISSUE;
            S_ISSUE: if (chan == CH_BOT_B) state_next = S_WAIT;
            S_WAIT:  if (tag_valid && tag_chan == CH_BOT_B) state_next = S_FULL;
            S_FULL:  if (load) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state        <= S_IDLE;
            chan         <= CH_TOP_R;
            row          <= '0;
            asm_row      <= '0;
            bank         <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            state <= state_next;
            if (issue) begin
                if (chan == CH_BOT_B) begin
                    chan    <= CH_TOP_R;
                    asm_row <= row;
                    row     <= row + ROW_ADDR_W'(1);
                end else begin
                    chan <= channel_e'(chan + 3'd1);
                end
            end
            // A request coinciding with the swap cycle re-arms for the next frame.
            if (swap_now) begin
                bank         <= ~bank;
                swap_pending <= bank_swap_in;
            end else if (bank_swap_in) begin
                swap_pending <= 1'b1;
            end
        end
    end

    led_display_rdata_tagger #(
        .LATENCY (RAM_LATENCY)
    ) u_tagger (
        .clk_in        (clk_in),
        .n_reset_in    (n_reset_in),
        .issue_in      (issue),
        .chan_in       (chan),
        .tag_valid_out (tag_valid),
        .tag_chan_out  (tag_chan)
    );

    // NOTE: the assembly slots carry no reset; clearing the tag valids is enough, since a row
    // is only presented after all six slots have been rewritten.
    always_ff @(posedge clk_in) begin
        if (tag_valid) begin
            slot[tag_chan] <= ram_rdata_in;
        end
    end

    for (genvar k = 0; k < GL_RGB_CHANNELS; k++) begin : g_flat
        assign asm_flat[k*ROW_W +: ROW_W] = slot[k];
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            row_valid_out   <= 1'b0;
            row_data_out    <= '0;
            row_address_out <= '0;
            row_first_out   <= 1'b0;
        end else if (load) begin
            row_valid_out   <= 1'b1;
            row_data_out    <= asm_flat;
            row_address_out <= asm_row;
            row_first_out   <= (asm_row == '0);
        end else if (row_ready_in) begin
            row_valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_display_frame_reader.sv
// Directed bench: one reader with a 1-cycle RAM and one with a 3-cycle RAM.
module tb_led_display_frame_reader;
    import led_display_package::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst1, en1, swap1, ack1, bank1, rd1, v1, first1, rdy1;
    logic [7:0]   addr1;
    logic [31:0]  rdata1;
    logic [191:0] data1;
    logic [3:0]   raddr1;

    logic         rst3, en3, swap3, ack3, bank3, rd3, v3, first3, rdy3;
    logic [7:0]   addr3;
    logic [31:0]  rdata3;
    logic [191:0] data3;
    logic [3:0]   raddr3;

    led_display_frame_reader #(.RAM_LATENCY(1)) dut1 (
        .clk_in(clk), .n_reset_in(rst1), .enable_in(en1), .bank_swap_in(swap1),
        .swap_ack_out(ack1), .bank_out(bank1), .ram_rd_en_out(rd1), .ram_address_out(addr1),
        .ram_rdata_in(rdata1), .row_data_out(data1), .row_valid_out(v1),
        .row_address_out(raddr1), .row_first_out(first1), .row_ready_in(rdy1)
    );

    led_display_frame_reader #(.RAM_LATENCY(3)) dut3 (
        .clk_in(clk), .n_reset_in(rst3), .enable_in(en3), .bank_swap_in(swap3),
        .swap_ack_out(ack3), .bank_out(bank3), .ram_rd_en_out(rd3), .ram_address_out(addr3),
        .ram_rdata_in(rdata3), .row_data_out(data3), .row_valid_out(v3),
        .row_address_out(raddr3), .row_first_out(first3), .row_ready_in(rdy3)
    );

    // RAM models: the stored word is the read address replicated; idle cycles return junk.
    logic [31:0] p3 [3];
    always @(posedge clk) begin
        rdata1 <= rd1 ? {4{addr1}} : 32'h0BAD_0BAD;
        p3[0]  <= rd3 ? {4{addr3}} : 32'h0BAD_0BAD;
        p3[1]  <= p3[0];
        p3[2]  <= p3[1];
    end
    assign rdata3 = p3[2];

    int checks = 0, failures = 0;
    int rd1_count = 0, rd3_count = 0, bad_chan = 0, acks1 = 0, ack_bad = 0, unstable3 = 0;
    logic         prev_v3 = 1'b0, prev_rdy3 = 1'b0;
    logic [191:0] prev_d3 = '0;

    always @(negedge clk) begin
        if (rd1) rd1_count <= rd1_count + 1;
        if (rd3) rd3_count <= rd3_count + 1;
        if ((rd1 && addr1[2:0] > 3'd5) || (rd3 && addr3[2:0] > 3'd5)) bad_chan <= bad_chan + 1;
        if (ack1) begin
            acks1 <= acks1 + 1;
            if (addr1 != 8'h80) ack_bad <= ack_bad + 1;
        end
        if (v3 && prev_v3 && !prev_rdy3 && data3 !== prev_d3) unstable3 <= unstable3 + 1;
        prev_v3   <= v3;
        prev_rdy3 <= rdy3;
        prev_d3   <= data3;
    end

    logic [3:0] exp_idx = 4'd0;
    logic       exp_bank = 1'b0, exp_pend = 1'b0;

    function automatic logic [191:0] exp_row(input logic b, input logic [3:0] r);
        rgb_row_t s;
        s.top_r = {4{b, r, 3'd0}};
        s.top_g = {4{b, r, 3'd1}};
        s.top_b = {4{b, r, 3'd2}};
        s.bot_r = {4{b, r, 3'd3}};
        s.bot_g = {4{b, r, 3'd4}};
        s.bot_b = {4{b, r, 3'd5}};
        return pack_row(s);
    endfunction

    task automatic check(input string tag, input logic [191:0] observed, input logic [191:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for dut1 to hand over a row, compare it with the model, then let the transfer happen.
    task automatic take_row1(input bit toggle);
        int n = 0;
        while (!(v1 && rdy1) && n < 200) begin
            step();
            n++;
            if (toggle) rdy1 = ~rdy1;
        end
        check("row_wait", n < 200, 1);
        check("row_addr", raddr1, exp_idx);
        check("row_first", first1, exp_idx == 4'd0);
        check("row_data", data1, exp_row(exp_bank, exp_idx));
        step();
        if (toggle) rdy1 = ~rdy1;
        exp_idx = exp_idx + 4'd1;
        if (exp_idx == 4'd0 && exp_pend) begin
            exp_bank = ~exp_bank;
            exp_pend = 1'b0;
        end
    endtask

    initial begin
        int n;
        int rdc;
        logic prev;
        rst1 = 1'b0; rst3 = 1'b0; en1 = 1'b0; en3 = 1'b0;
        swap1 = 1'b0; swap3 = 1'b0; rdy1 = 1'b1; rdy3 = 1'b0;
        repeat (3) step();

        check("rst_valid", v1, 0);
        check("rst_data", data1, 0);
        check("rst_rd_en", rd1, 0);
        check("rst_addr", addr1, 0);
        check("rst_ack_bank", {ack1, bank1, first1}, 0);
        rst1 = 1'b1; rst3 = 1'b1;
        step();

        // In-order frame with ready held high, plus first-row latency.
        en1 = 1'b1;
        n = 0;
        while (!rd1 && n < 20) begin step(); n++; end
        check("first_read_seen", n < 20, 1);
        n = 0;
        while (!v1 && n < 50) begin step(); n++; end
        check("first_valid_latency", n, 8);
        repeat (16) take_row1(1'b0);

        // Ready toggling every cycle: whole frame, no drops or duplicates.
        repeat (16) take_row1(1'b1);
        rdy1 = 1'b1;

        // Swap requests at rows 5 and 9 collapse into one swap at the next frame start.
        repeat (6) take_row1(1'b0);
        swap1 = 1'b1; exp_pend = 1'b1; step(); swap1 = 1'b0;
        repeat (4) take_row1(1'b0);
        swap1 = 1'b1; step(); swap1 = 1'b0;
        repeat (6) take_row1(1'b0);
        repeat (16) take_row1(1'b0);
        check("swap_ack_count", acks1, 1);
        check("swap_ack_position", ack_bad, 0);
        check("bank_after_swap", bank1, 1);

        // Enable dropped during chan 2 of row 7.
        repeat (7) take_row1(1'b0);
        n = 0;
        while (!(rd1 && addr1[6:3] == 4'd7 && addr1[2:0] == 3'd2) && n < 50) begin step(); n++; end
        check("row7_chan2_seen", n < 50, 1);
        en1 = 1'b0;
        take_row1(1'b0);
        rdc = rd1_count;
        repeat (30) step();
        check("no_reads_disabled", rd1_count, rdc);
        check("no_valid_disabled", v1, 0);
        en1 = 1'b1;
        take_row1(1'b0);

        // Latency-3 reader with ready held low: one row held, one prefetched, nothing more read.
        en3 = 1'b1;
        repeat (40) step();
        check("hold_valid", v3, 1);
        check("hold_addr", raddr3, 0);
        check("hold_first", first3, 1);
        check("hold_data", data3, exp_row(1'b0, 4'd0));
        check("hold_read_count", rd3_count, 12);
        check("hold_stable", unstable3, 0);
        rdy3 = 1'b1;
        step();
        check("b2b_valid", v3, 1);
        check("b2b_addr", raddr3, 1);
        check("b2b_first", first3, 0);
        check("b2b_data", data3, exp_row(1'b0, 4'd1));

        // Reset asserted in WAIT with reads still in flight.
        n = 0;
        prev = rd3;
        while (!(prev && !rd3) && n < 100) begin prev = rd3; step(); n++; end
        check("wait_phase_seen", n < 100, 1);
        rst3 = 1'b0;
        #1;
        check("async_rst_valid", v3, 0);
        check("async_rst_data", data3, 0);
        check("async_rst_rd", {rd3, addr3}, 0);
        check("async_rst_row", {raddr3, first3, bank3, ack3}, 0);
        step();
        rst3 = 1'b1;
        n = 0;
        while (!v3 && n < 50) begin step(); n++; end
        check("post_rst_valid_seen", n < 50, 1);
        check("post_rst_addr", raddr3, 0);
        check("post_rst_first", first3, 1);
        check("post_rst_bank", bank3, 0);
        check("post_rst_data", data3, exp_row(1'b0, 4'd0));

        check("no_chan_6_7", bad_chan, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
